// File: rtl/cpu7_alu.sv
// cpu7_alu: RV-style integer ALU with a valid/ready request/result handshake.
// Single-cycle ops (ADD/SUB/shifts/compares/logic) return their result one edge
// after acceptance. Define CPU7_ALU_MDU_EN to add an iterative MUL/DIVU/REMU
// unit (one bit per cycle, result XLEN+1 edges after acceptance); without it
// those encodings decode as illegal and busy is tied low.
module cpu7_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [1:0]      aluop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef CPU7_ALU_MDU_EN
  localparam logic [6:0] F7_MDU = 7'b0000001;
  localparam logic [SW:0] CNT_LAST = (SW+1)'(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t          state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  logic [XLEN-1:0] res_d;
  logic            ill_d;
  logic            accept;
  logic            is_r;
  logic            is_i;
  logic            f7_ok;
  logic [SW-1:0]   shamt;

`ifdef CPU7_ALU_MDU_EN
  logic            mdu_mul;
  logic            mdu_div;
  logic            mdu_rem;
  logic [SW:0]     cnt_q;
  logic [XLEN-1:0] opa_q;     // multiplicand (MUL) / dividend shifting into quotient (DIV)
  logic [XLEN-1:0] opb_q;     // multiplier (MUL) / divisor (DIV)
  logic [XLEN-1:0] acc_q;     // product accumulator (MUL) / partial remainder (DIV)
  logic            rem_sel_q;
  logic [XLEN-1:0] mul_acc_n;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_trial;
  logic            div_ok;
`endif

  assign busy      = `ifdef CPU7_ALU_MDU_EN (state_q == MUL) || (state_q == DIV) `else 1'b0 `endif ;
  assign in_ready  = !busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

  assign is_r  = (op == OP_REG);
  assign is_i  = (op == OP_IMM);
  // funct7 is don't-care for immediate forms of the non-shift ops
  assign f7_ok = is_i || (funct7 == F7_ZERO);
  assign shamt = b[SW-1:0];

  // Decode the request and compute the single-cycle result
  always_comb begin
    res_d = '0;
    ill_d = 1'b0;
`ifdef CPU7_ALU_MDU_EN
    mdu_mul = 1'b0;
    mdu_div = 1'b0;
    mdu_rem = 1'b0;
`endif
    case (aluop)
      2'b00: res_d = a + b;
      2'b01: res_d = a - b;
      2'b10: begin
        if (!(is_r || is_i)) begin
          ill_d = 1'b1;
        end else if (is_r && (funct7 == 7'b0000001)) begin
`ifdef CPU7_ALU_MDU_EN
          case (funct3)
            3'b000:  mdu_mul = 1'b1;
            3'b101:  mdu_div = 1'b1;
            3'b111: begin
              mdu_div = 1'b1;
              mdu_rem = 1'b1;
            end
            default: ill_d = 1'b1;
          endcase
`else
          ill_d = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000: begin
              if (is_r && (funct7 == F7_ALT)) res_d = a - b;
              else if (f7_ok)                 res_d = a + b;
              else                            ill_d = 1'b1;
            end
            3'b001: begin
              if (funct7 == F7_ZERO) res_d = a << shamt;
              else                   ill_d = 1'b1;
            end
            3'b010: begin
              if (f7_ok) res_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
              else       ill_d = 1'b1;
            end
            3'b011: begin
              if (f7_ok) res_d = {{(XLEN-1){1'b0}}, (a < b)};
              else       ill_d = 1'b1;
            end
            3'b100: begin
              if (f7_ok) res_d = a ^ b;
              else       ill_d = 1'b1;
            end
            3'b101: begin
              if (funct7 == F7_ZERO)     res_d = a >> shamt;
              else if (funct7 == F7_ALT) res_d = $unsigned($signed(a) >>> shamt);
              else                       ill_d = 1'b1;
            end
            3'b110: begin
              if (f7_ok) res_d = a | b;
              else       ill_d = 1'b1;
            end
            default: begin
              if (f7_ok) res_d = a & b;
              else       ill_d = 1'b1;
            end
          endcase
        end
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) res_d = '0;
  end

`ifdef CPU7_ALU_MDU_EN
  // One shift-add / restoring-division step from the iteration registers.
  // A zero divisor makes every trial subtraction succeed, which naturally
  // yields an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    mul_acc_n = acc_q + (opb_q[0] ? opa_q : '0);
    div_shift = {acc_q, opa_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opb_q};
    div_ok    = !div_trial[XLEN];
  end
`endif

  // Handshake FSM, iteration datapath and registered result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
`ifdef CPU7_ALU_MDU_EN
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      rem_sel_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
`ifdef CPU7_ALU_MDU_EN
        // XLEN iteration cycles (cnt 0..XLEN-1), then one cycle to register the result
        MUL: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc_q;
            illegal_q   <= 1'b0;
          end else begin
            acc_q <= mul_acc_n;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= rem_sel_q ? acc_q : opa_q;
            illegal_q   <= 1'b0;
          end else begin
            acc_q <= div_ok ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
            opa_q <= {opa_q[XLEN-2:0], div_ok};
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        IDLE, DONE: begin
          if (accept) begin
`ifdef CPU7_ALU_MDU_EN
            if (mdu_mul || mdu_div) begin
              state_q     <= mdu_mul ? MUL : DIV;
              out_valid_q <= 1'b0;
              cnt_q       <= '0;
              opa_q       <= a;
              opb_q       <= b;
              acc_q       <= '0;
              rem_sel_q   <= mdu_rem;
            end else
`endif
            begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              illegal_q   <= ill_d;
            end
          end else if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu7_alu.sv
// Directed, table-driven bench for cpu7_alu (XLEN=32). MDU sequences are
// compiled in only when CPU7_ALU_MDU_EN is defined, matching the RTL build.
module tb_cpu7_alu;

  localparam int unsigned XLEN = 32;
  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [1:0]      aluop;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic            busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  al;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t tv[$];

  cpu7_alu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .funct3    (funct3),
    .funct7    (funct7),
    .aluop     (aluop),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic void addv(input logic [1:0] al, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] va, input logic [31:0] vb,
                               input logic [31:0] res, input logic ill);
    vec_t v;
    v.al = al; v.opc = opc; v.f3 = f3; v.f7 = f7;
    v.va = va; v.vb = vb; v.res = res; v.ill = ill;
    tv.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] al, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] va, input logic [31:0] vb);
    aluop = al; op = opc; funct3 = f3; funct7 = f7; a = va; b = vb;
  endtask

  // Issue one single-cycle op and check its result on the following cycle
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    check($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    drive(v.al, v.opc, v.f3, v.f7, v.va, v.vb);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("vec%0d_out_valid", idx), out_valid, 1);
    check($sformatf("vec%0d_result", idx), result, v.res);
    check($sformatf("vec%0d_illegal", idx), illegal, v.ill);
  endtask

`ifdef CPU7_ALU_MDU_EN
  // Issue an MDU op, scramble operands after acceptance, measure latency
  task automatic run_mdu(input string nm, input logic [2:0] f3, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp);
    int n;
    int viol;
    @(negedge clk);
    drive(2'b10, R, f3, 7'b0000001, va, vb);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    n = 0;
    viol = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
      if (in_ready !== 1'b0 || busy !== 1'b1) viol++;
    end
    check({nm, "_latency"}, n, XLEN + 1);
    check({nm, "_busy_viol"}, viol, 0);
    check({nm, "_result"}, result, exp);
    check({nm, "_illegal"}, illegal, 0);
  endtask
`endif

  initial begin
    logic [31:0] held;
    in_valid = 1'b0; out_ready = 1'b0;
    drive(2'b00, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0);

    // Async reset asserted between edges takes effect immediately
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_illegal", illegal, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    addv(2'b00, 7'd0, 3'd0, 7'd0, 32'd5,          32'd7,          32'd12,         1'b0);
    addv(2'b01, 7'd0, 3'd0, 7'd0, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0);
    addv(2'b00, 7'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
    addv(2'b11, R, 3'd0, 7'd0,    32'd5,          32'd7,          32'd0,          1'b1);
    addv(2'b10, R, 3'd0, 7'h20,   32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0);
    addv(2'b10, R, 3'd0, 7'h00,   32'd3,          32'd4,          32'd7,          1'b0);
    addv(2'b10, I, 3'd5, 7'h20,   32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0);
    addv(2'b10, I, 3'd5, 7'h00,   32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0);
    addv(2'b10, R, 3'd1, 7'h00,   32'd1,          32'h21,         32'd2,          1'b0);
    addv(2'b10, R, 3'd2, 7'h00,   32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
    addv(2'b10, R, 3'd3, 7'h00,   32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
    addv(2'b10, R, 3'd4, 7'h00,   32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0);
    addv(2'b10, R, 3'd6, 7'h00,   32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0);
    addv(2'b10, R, 3'd7, 7'h00,   32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0);
    addv(2'b10, I, 3'd0, 7'h7F,   32'd10,         32'hFFFF_FFFF,  32'd9,          1'b0);
    addv(2'b10, I, 3'd2, 7'h20,   32'd3,          32'd5,          32'd1,          1'b0);
    addv(2'b10, R, 3'd0, 7'h7F,   32'd3,          32'd4,          32'd0,          1'b1);
    addv(2'b10, 7'b0000011, 3'd0, 7'h00, 32'd3,   32'd4,          32'd0,          1'b1);
    addv(2'b10, I, 3'd1, 7'h20,   32'd1,          32'd1,          32'd0,          1'b1);
    addv(2'b10, R, 3'd2, 7'h20,   32'd1,          32'd2,          32'd0,          1'b1);
    addv(2'b10, R, 3'd5, 7'h10,   32'd8,          32'd1,          32'd0,          1'b1);
    addv(2'b10, R, 3'd1, 7'h01,   32'd8,          32'd1,          32'd0,          1'b1);
`ifndef CPU7_ALU_MDU_EN
    addv(2'b10, R, 3'd0, 7'h01,   32'hFFFF,       32'h10001,      32'd0,          1'b1);
    addv(2'b10, R, 3'd5, 7'h01,   32'd100,        32'd7,          32'd0,          1'b1);
    addv(2'b10, R, 3'd7, 7'h01,   32'd100,        32'd7,          32'd0,          1'b1);
`endif

    foreach (tv[i]) run_vec(tv[i], i);

    // Back-pressure: result held while consumer stalls, operands changed meanwhile
    @(negedge clk);
    drive(2'b00, 7'd0, 3'd0, 7'd0, 32'h11, 32'h22);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    held = 32'h33;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_out_valid", k), out_valid, 1);
      check($sformatf("hold%0d_result", k), result, held);
      check($sformatf("hold%0d_in_ready", k), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_drained", out_valid, 0);
    check("hold_in_ready", in_ready, 1);

    // Back-to-back single-cycle ops, accept and drain in the same cycle
    drive(2'b00, 7'd0, 3'd0, 7'd0, 32'd1, 32'd100);
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_out_valid", k), out_valid, 1);
      check($sformatf("b2b%0d_result", k), result, 32'(100 + k));
      check($sformatf("b2b%0d_in_ready", k), in_ready, 1);
      if (k < 3) a = 32'(k + 1);
      else       in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_drained", out_valid, 0);

    // Reset while an illegal result is pending clears it immediately
    drive(2'b11, 7'd0, 3'd0, 7'd0, 32'd9, 32'd9);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("ill_pending_illegal", illegal, 1);
    check("ill_pending_result", result, 0);
    resetn = 1'b0;
    #1;
    check("ill_rst_out_valid", out_valid, 0);
    check("ill_rst_illegal", illegal, 0);
    @(negedge clk);
    resetn    = 1'b1;
    out_ready = 1'b1;

`ifdef CPU7_ALU_MDU_EN
    run_mdu("mul", 3'b000, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
    run_mdu("mul2", 3'b000, 32'd12345, 32'd678, 32'd8369910);
    run_mdu("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    run_mdu("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    run_mdu("divu0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF);
    run_mdu("remu0", 3'b111, 32'd100, 32'd0, 32'd100);

    // Reset mid-DIV abandons the operation
    begin
      int seen;
      @(negedge clk);
      drive(2'b10, R, 3'b101, 7'b0000001, 32'd1000, 32'd3);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("middiv_busy", busy, 1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("middiv_rst_out_valid", out_valid, 0);
      check("middiv_rst_busy", busy, 0);
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      check("middiv_no_stale", seen, 0);
      check("middiv_in_ready", in_ready, 1);
    end
`endif

    // Sanity op after all the resets
    addv(2'b01, 7'd0, 3'd0, 7'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    run_vec(tv[tv.size()-1], tv.size()-1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
